pll_lock_sequencer: RTL

Sequences start-up and recovery of one CC_PLL instance and generates a clean, lock-qualified reset for logic in the PLL output domain. It pulses the PLL's steady-lock reset, waits for lock with a timeout, and requires lock to hold for a settle window before releasing downstream reset. It retries a bounded number of times, then latches a failure flag. It runs on the reference clock that feeds the PLL, so it keeps running while the PLL is unlocked.

---
 rtl/pll_ctrl_pkg.sv | 29 ++
 rtl/sync_2ff.sv | 32 +++
 rtl/pll_lock_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/pll_ctrl_pkg.sv
// ============================================================================
// Module   : pll_ctrl_pkg
// Brief    : Shared types and helpers for the PLL lock sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        SETTLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } pll_state_e;

    // Wide enough for the largest cycle count, plus one bit of headroom.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module   : sync_2ff
// Brief    : Two-flop synchronizer, async active-low reset, resets to 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/pll_lock_sequencer.sv
// ============================================================================
// Module   : pll_lock_sequencer
// Brief    : PLL start-up/recovery sequencer producing a lock-qualified reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_lock_sequencer
    import pll_ctrl_pkg::*;
#(
    parameter int STDY_RST_CYCLES = 4,
    parameter int LOCK_TIMEOUT    = 100000,
    parameter int SETTLE_CYCLES   = 1024,
    parameter int MAX_RETRIES     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked_stdy,
    input  logic       retry_req,
    output logic       pll_stdy_rst,
    output logic       user_rst_n,
    output logic       locked,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    localparam int CNT_W = cnt_width(STDY_RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] STDY_LAST   = CNT_W'(STDY_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRIES);

    logic             lock_s;
    pll_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic [7:0]       loss_q, loss_d;
    logic             stdy_rst_q, user_rst_n_q, locked_q, fail_q;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst),
        .d_i   (pll_locked_stdy),
        .q_o   (lock_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        loss_d  = loss_q;

        case (state_q)
            RESET_PLL: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == STDY_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                cnt_d = cnt_q + CNT_ONE;
                // Lock seen on the timeout cycle still wins over the retry.
                if (lock_s) begin
                    state_d = SETTLE;
                end else if (cnt_q == TMO_LAST) begin
                    if (retry_q == RETRY_MAX) begin
                        state_d = FAIL;
                    end else begin
                        retry_d = retry_q + 4'd1;
                        state_d = RESET_PLL;
                    end
                end
            end
            SETTLE: begin
                cnt_d = cnt_q + CNT_ONE;
                if (!lock_s)                    state_d = WAIT_LOCK;
                else if (cnt_q == SETTLE_LAST)  state_d = RUN;
            end
            RUN: begin
                if (!lock_s) begin
                    if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                    retry_d = 4'd0;
                    state_d = RESET_PLL;
                end
            end
            FAIL: begin
                if (retry_req) begin
                    retry_d = 4'd0;
                    state_d = RESET_PLL;
                end
            end
            default: state_d = RESET_PLL;
        endcase

        if (state_d != state_q) cnt_d = '0;
    end

    // Outputs decode next-state so they change on the edge entering a state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RESET_PLL;
            cnt_q        <= '0;
            retry_q      <= 4'd0;
            loss_q       <= 8'd0;
            stdy_rst_q   <= 1'b1;
            user_rst_n_q <= 1'b0;
            locked_q     <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            loss_q       <= loss_d;
            stdy_rst_q   <= (state_d == RESET_PLL);
            user_rst_n_q <= (state_d == RUN);
            locked_q     <= (state_d == RUN);
            fail_q       <= (state_d == FAIL);
        end
    end

    assign pll_stdy_rst = stdy_rst_q;
    assign user_rst_n   = user_rst_n_q;
    assign locked       = locked_q;
    assign fail         = fail_q;
    assign retry_cnt    = retry_q;
    assign loss_cnt     = loss_q;

endmodule

`default_nettype wire
